rsa_cmd_engine: RTL and testbench
=================================

RSA_CMD_ENGINE -- requirements
Module: rsa_cmd_engine

Interface
REQ-001 SHALL have parameter RSA_BITS, default 1024, operand width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 4, operand register count (2..16).
REQ-003 SHALL have parameter LIMB_BITS, default 64, add/sub datapath width; RSA_BITS SHALL be a multiple of LIMB_BITS.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port bram_din, input, RSA_BITS, operand from DMA/BRAM.
REQ-007 SHALL have port bram_din_valid, input, 1, bram_din valid.
REQ-008 SHALL have port bram_dout, output, RSA_BITS, result to BRAM.
REQ-009 SHALL have port bram_dout_valid, output, 1, bram_dout holds data to store.
REQ-010 SHALL have port bram_dout_read, input, 1, BRAM interface consumed bram_dout.
REQ-011 SHALL have port port1_din, input, 32, command word.
REQ-012 SHALL have port port1_valid, input, 1, command available.
REQ-013 SHALL have port port1_read, output, 1, command consumed.
REQ-014 SHALL have port port2_dout, output, 32, completion status.
REQ-015 SHALL have port port2_valid, output, 1, status valid.
REQ-016 SHALL have port port2_read, input, 1, status consumed.
REQ-017 SHALL have port leds, output, 4, current FSM state code.

Function
REQ-018 Command fields SHALL be: [3:0] opcode, [7:4] dst, [11:8] srcA, [15:12] srcB; [31:16] ignored.
REQ-019 Opcodes SHALL be: 0 LOAD R[dst]<=bram_din; 1 ADD R[dst]<=R[a]+R[b] mod 2^RSA_BITS; 2 STORE bram_dout<=R[a]; 3 SUB R[dst]<=R[a]-R[b] mod 2^RSA_BITS; 4 XOR R[dst]<=R[a]^R[b].
REQ-020 FSM states SHALL be IDLE, LOAD, ALU, STORE, DONE; leds SHALL be IDLE=0, LOAD=1, ALU=2, STORE=3, DONE=4.
REQ-021 In IDLE with port1_valid=1 the FSM SHALL latch port1_din and assert port1_read for exactly one cycle on the next edge.
REQ-022 An opcode >4, or any used index >= NUM_REGS, SHALL go IDLE->DONE with status error bit set and no register change.
REQ-023 LOAD SHALL wait indefinitely for bram_din_valid, capture bram_din into R[dst] on that edge, then go to DONE.
REQ-024 ADD/SUB SHALL process one LIMB_BITS limb per cycle LSB-first, taking exactly RSA_BITS/LIMB_BITS ALU cycles, carry/borrow registered between limbs.
REQ-025 XOR SHALL take exactly one ALU cycle.
REQ-026 ALU results SHALL accumulate in a shadow register committed to R[dst] on the last ALU cycle, so dst may equal srcA or srcB.
REQ-027 STORE SHALL drive bram_dout=R[a] with bram_dout_valid=1 until the cycle bram_dout_read=1, then go to DONE.
REQ-028 DONE SHALL hold port2_valid=1 and port2_dout stable until port2_read=1, then return to IDLE.
REQ-029 port2_dout SHALL be: [3:0] echoed opcode, bit 4 error, bit 5 final carry (ADD) or borrow (SUB), else 0; [31:6]=0.
REQ-030 No new command SHALL be accepted outside IDLE; port1_read SHALL stay 0 there.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, clear all registers, shadow, carry, latched command, and drive port1_read, port2_valid, bram_dout_valid, port2_dout, leds to 0; bram_dout to 0.
REQ-032 Reset mid-operation SHALL abort it; no partial result SHALL survive.

Structure
REQ-033 Opcode values, state encodings, command field positions, status bit positions SHALL reside in shared package rsa_cmd_pkg.
REQ-034 The limb-serial add/sub datapath SHALL be sub-module rsa_limb_addsub (LIMB_BITS wide, registered carry, add/sub select).

Verification
REQ-035 LOAD R0=0x1, R1=all-ones, ADD dst2 -> after 16 ALU cycles R2=0, status=0x21.
REQ-036 LOAD R0=5, R1=7, SUB dst0 a0 b1 -> R0=2^1024-2, status=0x23; then STORE a0 -> bram_dout=2^1024-2.
REQ-037 R0=0xDEADBEEF<<992, XOR dst0 a0 b0 -> R0=0, completes in 1 ALU cycle, status=0x04.
REQ-038 Opcode 7, then ADD with srcB=5 (NUM_REGS=4) -> status 0x17 and 0x11, registers unchanged.
REQ-039 Hold bram_dout_read=0 for 20 cycles in STORE, port2_read=0 for 10 in DONE -> valids held, port1_read stays 0.
REQ-040 resetn=0 at ALU cycle 8 of ADD -> all outputs 0 immediately, registers 0, next command accepted normally.

Source files
------------

// File: rtl/rsa_cmd_pkg.sv
// Shared encodings for the RSA command engine: opcodes, FSM states,
// command field positions and status word layout.
package rsa_cmd_pkg;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'd0,
      OP_ADD   = 4'd1,
      OP_STORE = 4'd2,
      OP_SUB   = 4'd3,
      OP_XOR   = 4'd4
   } opcode_e;

   // Encodings double as the LED code shown on the board.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ALU   = 3'd2,
      ST_STORE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int unsigned CMD_W    = 32;
   localparam int unsigned FIELD_W  = 4;
   localparam int unsigned OP_LSB   = 0;
   localparam int unsigned DST_LSB  = 4;
   localparam int unsigned SRCA_LSB = 8;
   localparam int unsigned SRCB_LSB = 12;

   localparam int unsigned STAT_W         = 32;
   localparam int unsigned STAT_OP_LSB    = 0;
   localparam int unsigned STAT_ERR_BIT   = 4;
   localparam int unsigned STAT_CARRY_BIT = 5;

   // True when the command is unknown or names a register that does not exist.
   function automatic logic cmd_error(input logic [CMD_W-1:0] cmd,
                                      input int unsigned num_regs);
      logic [FIELD_W-1:0] op, dst, a, b;
      logic bad_dst, bad_a, bad_b;
      op      = cmd[OP_LSB   +: FIELD_W];
      dst     = cmd[DST_LSB  +: FIELD_W];
      a       = cmd[SRCA_LSB +: FIELD_W];
      b       = cmd[SRCB_LSB +: FIELD_W];
      bad_dst = 32'(dst) >= num_regs;
      bad_a   = 32'(a) >= num_regs;
      bad_b   = 32'(b) >= num_regs;
      case (op)
         OP_LOAD:                cmd_error = bad_dst;
         OP_STORE:               cmd_error = bad_a;
         OP_ADD, OP_SUB, OP_XOR: cmd_error = bad_dst | bad_a | bad_b;
         default:                cmd_error = 1'b1;
      endcase
   endfunction

   function automatic logic [STAT_W-1:0] make_status(input logic [FIELD_W-1:0] op,
                                                     input logic err,
                                                     input logic carry);
      make_status = '0;
      make_status[STAT_OP_LSB +: FIELD_W] = op;
      make_status[STAT_ERR_BIT]           = err;
      make_status[STAT_CARRY_BIT]         = carry;
   endfunction

endpackage

// File: rtl/rsa_cmd_engine_addsub.sv
// One limb of a serial add/subtract; the carry/borrow is held between limbs.
module rsa_limb_addsub #(
   parameter int unsigned LIMB_BITS = 64
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 sub,
   input  logic [LIMB_BITS-1:0] a,
   input  logic [LIMB_BITS-1:0] b,
   output logic [LIMB_BITS-1:0] sum,
   output logic                 carry_out
);

   logic                 carry_q;
   logic [LIMB_BITS:0]   full;

   // Extended-width add/sub: the top bit is the carry (add) or borrow (sub).
   always_comb begin
      if (sub) full = {1'b0, a} - {1'b0, b} - (LIMB_BITS+1)'(carry_q);
      else     full = {1'b0, a} + {1'b0, b} + (LIMB_BITS+1)'(carry_q);
      sum       = full[LIMB_BITS-1:0];
      carry_out = full[LIMB_BITS];
   end

   // Carry register, cleared before each new operation.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  carry_q <= 1'b0;
      else if (clr) carry_q <= 1'b0;
      else if (en)  carry_q <= full[LIMB_BITS];
   end

endmodule

// File: rtl/rsa_cmd_engine.sv
// Command-driven operand engine: load/store operands over the BRAM port and
// run limb-serial add/sub or single-cycle xor on a small register file.
module rsa_cmd_engine
   import rsa_cmd_pkg::*;
#(
   parameter int unsigned RSA_BITS  = 1024,
   parameter int unsigned NUM_REGS  = 4,
   parameter int unsigned LIMB_BITS = 64
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [RSA_BITS-1:0] bram_din,
   input  logic                bram_din_valid,
   output logic [RSA_BITS-1:0] bram_dout,
   output logic                bram_dout_valid,
   input  logic                bram_dout_read,
   input  logic [31:0]         port1_din,
   input  logic                port1_valid,
   output logic                port1_read,
   output logic [31:0]         port2_dout,
   output logic                port2_valid,
   input  logic                port2_read,
   output logic [3:0]          leds
);

   localparam int unsigned NUM_LIMBS = RSA_BITS / LIMB_BITS;
   localparam int unsigned CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
   localparam int unsigned IDX_W     = $clog2(NUM_REGS);

   state_e               state, state_nxt;
   logic [FIELD_W-1:0]   op_q;
   logic [IDX_W-1:0]     dst_q, a_q, b_q;
   logic [RSA_BITS-1:0]  regs [NUM_REGS];
   logic [RSA_BITS-1:0]  shadow, alu_res;
   logic [CNT_W-1:0]     cnt;
   logic [STAT_W-1:0]    status;
   logic [LIMB_BITS-1:0] limb_a, limb_b, limb_sum;
   logic                 limb_carry, alu_last, in_err;
   logic [FIELD_W-1:0]   in_op;

   assign in_op    = port1_din[OP_LSB +: FIELD_W];
   assign in_err   = cmd_error(port1_din, NUM_REGS);
   assign alu_last = (op_q == OP_XOR) || (cnt == CNT_W'(NUM_LIMBS - 1));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt       = state;
      port1_read      = 1'b0;
      bram_dout_valid = 1'b0;
      port2_valid     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (port1_valid) begin
               port1_read = resetn;
               if (in_err) state_nxt = ST_DONE;
               else begin
                  case (in_op)
                     OP_LOAD:  state_nxt = ST_LOAD;
                     OP_STORE: state_nxt = ST_STORE;
                     default:  state_nxt = ST_ALU;
                  endcase
               end
            end
         end
         ST_LOAD:  if (bram_din_valid) state_nxt = ST_DONE;
         ST_ALU:   if (alu_last) state_nxt = ST_DONE;
         ST_STORE: begin
            bram_dout_valid = 1'b1;
            if (bram_dout_read) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            port2_valid = 1'b1;
            if (port2_read) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign leds       = {1'b0, state};
   assign port2_dout = status;
   assign bram_dout  = (state == ST_STORE) ? regs[a_q] : '0;

   // Select the operand limbs addressed by the limb counter.
   always_comb begin
      limb_a = '0;
      limb_b = '0;
      for (int unsigned i = 0; i < NUM_LIMBS; i++) begin
         if (cnt == CNT_W'(i)) begin
            limb_a = regs[a_q][i*LIMB_BITS +: LIMB_BITS];
            limb_b = regs[b_q][i*LIMB_BITS +: LIMB_BITS];
         end
      end
   end

   // Shadow with the current limb merged in; this is the full result on the last limb.
   always_comb begin
      alu_res = shadow;
      for (int unsigned i = 0; i < NUM_LIMBS; i++) begin
         if (cnt == CNT_W'(i)) alu_res[i*LIMB_BITS +: LIMB_BITS] = limb_sum;
      end
   end

   rsa_limb_addsub #(
      .LIMB_BITS (LIMB_BITS)
   ) u_addsub (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (state != ST_ALU),
      .en        (state == ST_ALU),
      .sub       (op_q == OP_SUB),
      .a         (limb_a),
      .b         (limb_b),
      .sum       (limb_sum),
      .carry_out (limb_carry)
   );

   // Command latch, register file, shadow accumulator and status word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q   <= '0;
         dst_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         shadow <= '0;
         cnt    <= '0;
         status <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (port1_valid) begin
                  op_q   <= in_op;
                  dst_q  <= port1_din[DST_LSB  +: IDX_W];
                  a_q    <= port1_din[SRCA_LSB +: IDX_W];
                  b_q    <= port1_din[SRCB_LSB +: IDX_W];
                  shadow <= '0;
                  cnt    <= '0;
                  status <= make_status(in_op, in_err, 1'b0);
               end
            end
            ST_LOAD: if (bram_din_valid) regs[dst_q] <= bram_din;
            ST_ALU: begin
               shadow <= alu_res;
               cnt    <= cnt + 1'b1;
               // Commit only on the last limb so dst may alias a source.
               if (alu_last) begin
                  if (op_q == OP_XOR) regs[dst_q] <= regs[a_q] ^ regs[b_q];
                  else begin
                     regs[dst_q] <= alu_res;
                     status      <= make_status(op_q, 1'b0, limb_carry);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_cmd_engine.sv
// Randomised and directed bench for rsa_cmd_engine against an arithmetic
// reference model of the register file.
module tb_rsa_cmd_engine;

   localparam int unsigned RB = 1024;
   localparam int unsigned NR = 4;
   localparam int unsigned LB = 64;
   localparam int unsigned NL = RB / LB;

   logic          clk = 1'b0;
   logic          resetn;
   logic [RB-1:0] bram_din;
   logic          bram_din_valid;
   logic [RB-1:0] bram_dout;
   logic          bram_dout_valid;
   logic          bram_dout_read;
   logic [31:0]   port1_din;
   logic          port1_valid;
   logic          port1_read;
   logic [31:0]   port2_dout;
   logic          port2_valid;
   logic          port2_read;
   logic [3:0]    leds;

   always #5 clk = ~clk;

   rsa_cmd_engine #(
      .RSA_BITS  (RB),
      .NUM_REGS  (NR),
      .LIMB_BITS (LB)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .bram_din        (bram_din),
      .bram_din_valid  (bram_din_valid),
      .bram_dout       (bram_dout),
      .bram_dout_valid (bram_dout_valid),
      .bram_dout_read  (bram_dout_read),
      .port1_din       (port1_din),
      .port1_valid     (port1_valid),
      .port1_read      (port1_read),
      .port2_dout      (port2_dout),
      .port2_valid     (port2_valid),
      .port2_read      (port2_read),
      .leds            (leds)
   );

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [RB-1:0] mdl [NR];
   logic [31:0]   last_status;
   logic [RB-1:0] last_dout;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_wide(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
      for (int i = 0; i < int'(RB / 256); i++)
         check($sformatf("%s[%0d]", tag, i), got[i*256 +: 256], exp[i*256 +: 256]);
   endtask

   function automatic logic [RB-1:0] rand_wide();
      logic [RB-1:0] r;
      for (int i = 0; i < int'(RB / 32); i++) r[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0:       r = '0;
         1:       r = '1;
         2:       r = RB'(1);
         default: ;
      endcase
      return r;
   endfunction

   // Issue one command, service the BRAM side, and check status/timing
   // against the model (which is updated here as well).
   task automatic run_cmd(input logic [3:0] op, input logic [3:0] dst,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [RB-1:0] din, input int unsigned store_hold,
                          input int unsigned done_hold, input int unsigned load_delay);
      logic          err, carry, finished;
      logic [31:0]   exp_status, got_status;
      logic [RB-1:0] va, vb, exp_dout, got_dout;
      logic [RB:0]   full;
      int unsigned   exp_alu, alu_n, st_n, dn_n, ld_n, p1_bad, hold_bad;
      va = (a < NR) ? mdl[a[1:0]] : '0;
      vb = (b < NR) ? mdl[b[1:0]] : '0;
      case (op)
         4'd0:             err = dst >= NR;
         4'd2:             err = a >= NR;
         4'd1, 4'd3, 4'd4: err = (dst >= NR) || (a >= NR) || (b >= NR);
         default:          err = 1'b1;
      endcase
      carry = 1'b0; exp_alu = 0; exp_dout = '0;
      if (!err) begin
         case (op)
            4'd0: mdl[dst[1:0]] = din;
            4'd1: begin
               full = {1'b0, va} + {1'b0, vb};
               carry = full[RB];
               mdl[dst[1:0]] = full[RB-1:0];
               exp_alu = NL;
            end
            4'd2: exp_dout = va;
            4'd3: begin
               carry = va < vb;
               mdl[dst[1:0]] = va - vb;
               exp_alu = NL;
            end
            default: begin
               mdl[dst[1:0]] = va ^ vb;
               exp_alu = 1;
            end
         endcase
      end
      exp_status = {26'd0, carry, err, op};

      @(negedge clk);
      port1_din   = {16'($urandom), b, a, dst, op};
      port1_valid = 1'b1;
      #1 check("accept_read", 256'(port1_read), 256'(1));
      alu_n = 0; st_n = 0; dn_n = 0; ld_n = 0; p1_bad = 0; hold_bad = 0;
      finished = 1'b0; got_status = '1; got_dout = '1;
      for (int k = 0; k < 400 && !finished; k++) begin
         @(negedge clk);
         bram_din_valid = 1'b0; bram_dout_read = 1'b0; port2_read = 1'b0;
         #1;
         if (port1_read) p1_bad++;
         case (leds)
            4'd1: begin
               if (ld_n >= load_delay) begin bram_din = din; bram_din_valid = 1'b1; end
               else bram_din = ~din;
               ld_n++;
            end
            4'd2: alu_n++;
            4'd3: begin
               if (st_n == 0) got_dout = bram_dout;
               if (!bram_dout_valid || bram_dout !== exp_dout) hold_bad++;
               if (st_n >= store_hold) bram_dout_read = 1'b1;
               st_n++;
            end
            4'd4: begin
               if (dn_n == 0) got_status = port2_dout;
               if (!port2_valid || port2_dout !== exp_status) hold_bad++;
               if (dn_n >= done_hold) begin
                  port2_read = 1'b1; port1_valid = 1'b0; finished = 1'b1;
               end
               dn_n++;
            end
            default: ;
         endcase
      end
      check("done_reached", 256'(finished), 256'(1));
      check("status", 256'(got_status), 256'(exp_status));
      check("alu_cycles", 256'(alu_n), 256'(exp_alu));
      check("p1_read_busy", 256'(p1_bad), 256'(0));
      check("valid_hold", 256'(hold_bad), 256'(0));
      check("done_cycles", 256'(dn_n), 256'(done_hold + 1));
      if (op == 4'd2 && !err) begin
         check("store_cycles", 256'(st_n), 256'(store_hold + 1));
         check_wide("store_data", got_dout, exp_dout);
      end
      last_status = got_status;
      last_dout   = got_dout;
      @(negedge clk);
      port2_read = 1'b0;
      port1_valid = 1'b0;
      #1 check("back_idle", 256'(leds), 256'(0));
   endtask

   task automatic store_all();
      for (int r = 0; r < int'(NR); r++)
         run_cmd(4'd2, 4'd0, 4'(r), 4'd0, '0, $urandom_range(0, 2), $urandom_range(0, 2), 0);
   endtask

   initial begin
      logic [RB-1:0] v;
      logic [3:0]    op, dst, a, b;
      int unsigned   alu_seen;

      resetn = 1'b0; bram_din = '0; bram_din_valid = 1'b0; bram_dout_read = 1'b0;
      port1_din = '0; port1_valid = 1'b1; port2_read = 1'b0;
      for (int r = 0; r < int'(NR); r++) mdl[r] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_leds", 256'(leds), 256'(0));
      check("rst_p1_read", 256'(port1_read), 256'(0));
      check("rst_p2_valid", 256'(port2_valid), 256'(0));
      check("rst_p2_dout", 256'(port2_dout), 256'(0));
      check("rst_dout_valid", 256'(bram_dout_valid), 256'(0));
      port1_valid = 1'b0;
      resetn = 1'b1;

      // Carry out of the top limb.
      run_cmd(4'd0, 4'd0, 4'd0, 4'd0, RB'(1), 0, 0, 3);
      run_cmd(4'd0, 4'd1, 4'd0, 4'd0, '1, 0, 0, 0);
      run_cmd(4'd1, 4'd2, 4'd0, 4'd1, '0, 0, 0, 0);
      check("add_status", 256'(last_status), 256'(32'h21));
      run_cmd(4'd2, 4'd0, 4'd2, 4'd0, '0, 0, 0, 0);
      check_wide("add_result", last_dout, '0);

      // Borrow, dst aliasing a source, long STORE/DONE stalls.
      run_cmd(4'd0, 4'd0, 4'd0, 4'd0, RB'(5), 0, 0, 0);
      run_cmd(4'd0, 4'd1, 4'd0, 4'd0, RB'(7), 0, 0, 0);
      run_cmd(4'd3, 4'd0, 4'd0, 4'd1, '0, 0, 0, 0);
      check("sub_status", 256'(last_status), 256'(32'h23));
      run_cmd(4'd2, 4'd0, 4'd0, 4'd0, '0, 20, 10, 0);
      v = '1; v = v - RB'(1);
      check_wide("sub_result", last_dout, v);

      // Self-xor clears the register in one ALU cycle.
      v = '0; v[RB-1 -: 32] = 32'hDEADBEEF;
      run_cmd(4'd0, 4'd0, 4'd0, 4'd0, v, 0, 0, 0);
      run_cmd(4'd4, 4'd0, 4'd0, 4'd0, '0, 0, 0, 0);
      check("xor_status", 256'(last_status), 256'(32'h04));
      run_cmd(4'd2, 4'd0, 4'd0, 4'd0, '0, 0, 0, 0);
      check_wide("xor_result", last_dout, '0);

      // Illegal opcode and out-of-range source.
      run_cmd(4'd7, 4'd0, 4'd0, 4'd0, '0, 0, 0, 0);
      check("bad_op_status", 256'(last_status), 256'(32'h17));
      run_cmd(4'd1, 4'd0, 4'd0, 4'd5, '0, 0, 0, 0);
      check("bad_idx_status", 256'(last_status), 256'(32'h11));
      store_all();

      // Random command stream.
      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(0, 6));
         if (op > 4'd4) op = 4'($urandom_range(5, 15));
         dst = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         a   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         b   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         run_cmd(op, dst, a, b, rand_wide(), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      end
      store_all();

      // Reset in the middle of an ADD.
      run_cmd(4'd0, 4'd0, 4'd0, 4'd0, '1, 0, 0, 0);
      @(negedge clk);
      port1_din = 32'h0000_1021;
      port1_valid = 1'b1;
      alu_seen = 0;
      for (int k = 0; k < 100 && alu_seen < 8; k++) begin
         @(negedge clk);
         #1 if (leds == 4'd2) alu_seen++;
      end
      check("mid_add_reached", 256'(alu_seen), 256'(8));
      resetn = 1'b0;
      #1;
      check("abort_leds", 256'(leds), 256'(0));
      check("abort_p1_read", 256'(port1_read), 256'(0));
      check("abort_p2_valid", 256'(port2_valid), 256'(0));
      check("abort_p2_dout", 256'(port2_dout), 256'(0));
      check("abort_dout_valid", 256'(bram_dout_valid), 256'(0));
      check_wide("abort_dout", bram_dout, '0);
      for (int r = 0; r < int'(NR); r++) mdl[r] = '0;
      @(negedge clk);
      port1_valid = 1'b0;
      resetn = 1'b1;
      store_all();
      run_cmd(4'd0, 4'd3, 4'd0, 4'd0, rand_wide(), 0, 0, 1);
      run_cmd(4'd1, 4'd1, 4'd3, 4'd3, '0, 0, 0, 0);
      store_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
